// File: rtl/lcd_drv_nbit.sv
// HD44780-class LCD write engine: one byte per valid/ready handshake, sequenced
// as RS/data setup, E pulse, hold and execution wait, over an 8-bit or 4-bit bus.
module lcd_drv_nbit #(
    parameter int BUS_W  = 8,
    parameter int T_SU   = 2,
    parameter int T_EN   = 12,
    parameter int T_HOLD = 2,
    parameter int T_EXEC = 1850,
    parameter int T_LONG = 76000,
    parameter int CNT_W  = 17
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [7:0]       data_i,
    input  logic             rs_i,
    input  logic             data_valid_i,
    output logic             device_ready_o,
    output logic             rs_o,
    output logic             en_o,
    output logic [BUS_W-1:0] lcd_data_o
);

    // Handshake: a byte transfers on a rising edge where data_valid_i and
    // device_ready_o are both 1; while ready is 0 the inputs are ignored and
    // upstream must keep valid asserted until it sees ready.

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_EXEC  = 3'd4;

    localparam logic [CNT_W-1:0] LD_SU   = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] LD_EN   = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] LD_HOLD = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_EXEC = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_LONG = CNT_W'(T_LONG - 1);

    localparam bit TWO_BEATS = (BUS_W == 4);

    logic [2:0]       state;
    logic [CNT_W-1:0] timer;
    logic [7:0]       byte_q;
    logic             beat_q;
    logic             timer_done;
    logic             is_long;

    assign timer_done = (timer == '0);

    // Clear Display (0x01) and Return Home (0x02/0x03) need the long wait;
    // rs_o holds the latched register-select of the byte in flight.
    assign is_long = !rs_o &&
                     ((byte_q[7:1] == 7'b0000000) ||
                      ((byte_q[7:2] == 6'b000000) && byte_q[1]));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= ST_IDLE;
            timer          <= '0;
            byte_q         <= '0;
            beat_q         <= 1'b0;
            device_ready_o <= 1'b1;
            rs_o           <= 1'b0;
            en_o           <= 1'b0;
            lcd_data_o     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_valid_i) begin
                        byte_q         <= data_i;
                        rs_o           <= rs_i;
                        // First beat is the whole byte, or the high nibble in 4-bit mode.
                        lcd_data_o     <= data_i[7 -: BUS_W];
                        beat_q         <= 1'b0;
                        device_ready_o <= 1'b0;
                        timer          <= LD_SU;
                        state          <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (timer_done) begin
                        en_o  <= 1'b1;
                        timer <= LD_EN;
                        state <= ST_PULSE;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end

                ST_PULSE: begin
                    if (timer_done) begin
                        en_o  <= 1'b0;
                        timer <= LD_HOLD;
                        state <= ST_HOLD;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end

                ST_HOLD: begin
                    if (timer_done) begin
                        if (TWO_BEATS && !beat_q) begin
                            // Low nibble follows straight away; the LCD only
                            // executes once both nibbles have arrived.
                            beat_q     <= 1'b1;
                            lcd_data_o <= byte_q[BUS_W-1:0];
                            timer      <= LD_SU;
                            state      <= ST_SETUP;
                        end else begin
                            timer <= is_long ? LD_LONG : LD_EXEC;
                            state <= ST_EXEC;
                        end
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end

                ST_EXEC: begin
                    if (timer_done) begin
                        device_ready_o <= 1'b1;
                        state          <= ST_IDLE;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end

                default: begin
                    en_o           <= 1'b0;
                    device_ready_o <= 1'b1;
                    timer          <= '0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_drv_nbit.sv
// Directed bench for lcd_drv_nbit: an 8-bit and a 4-bit instance with short
// timing (T_SU=1, T_EN=3, T_HOLD=1, T_EXEC=5, T_LONG=20).
module tb_lcd_drv_nbit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] d8 = '0;
    logic       rs8 = 1'b0;
    logic       v8 = 1'b0;
    logic       ready8;
    logic       rs8_o;
    logic       en8;
    logic [7:0] data8;

    logic [7:0] d4 = '0;
    logic       rs4 = 1'b0;
    logic       v4 = 1'b0;
    logic       ready4;
    logic       rs4_o;
    logic       en4;
    logic [3:0] data4;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    lcd_drv_nbit #(
        .BUS_W(8), .T_SU(1), .T_EN(3), .T_HOLD(1), .T_EXEC(5), .T_LONG(20), .CNT_W(17)
    ) u_dut8 (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .data_i         (d8),
        .rs_i           (rs8),
        .data_valid_i   (v8),
        .device_ready_o (ready8),
        .rs_o           (rs8_o),
        .en_o           (en8),
        .lcd_data_o     (data8)
    );

    lcd_drv_nbit #(
        .BUS_W(4), .T_SU(1), .T_EN(3), .T_HOLD(1), .T_EXEC(5), .T_LONG(20), .CNT_W(17)
    ) u_dut4 (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .data_i         (d4),
        .rs_i           (rs4),
        .data_valid_i   (v4),
        .device_ready_o (ready4),
        .rs_o           (rs4_o),
        .en_o           (en4),
        .lcd_data_o     (data4)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single 8-bit write; edges counted from acceptance (edge 0). With glitch
    // set, a 1-cycle valid carrying 0xFF lands on edge 4 of the transfer.
    task automatic run8(input string tag, input logic [7:0] b, input logic r,
                        input int rdy_e, input bit glitch);
        check({tag, " ready_pre"}, {7'b0, ready8}, 8'd1);
        d8 = b;
        rs8 = r;
        v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        check({tag, " ready_e0"}, {7'b0, ready8}, 8'd0);
        for (int e = 1; e <= rdy_e; e++) begin
            @(posedge clk); #1;
            check($sformatf("%s en_e%0d", tag, e), {7'b0, en8},
                  {7'b0, (e >= 1 && e <= 3)});
            check($sformatf("%s ready_e%0d", tag, e), {7'b0, ready8},
                  {7'b0, (e == rdy_e)});
            check($sformatf("%s data_e%0d", tag, e), data8, b);
            check($sformatf("%s rs_e%0d", tag, e), {7'b0, rs8_o}, {7'b0, r});
            if (glitch && e == 3) begin
                v8 = 1'b1;
                d8 = 8'hFF;
            end
            if (glitch && e == 4) begin
                v8 = 1'b0;
                d8 = 8'hC3;
            end
        end
    endtask

    initial begin
        // Reset state of both instances.
        #12;
        check("rst ready8", {7'b0, ready8}, 8'd1);
        check("rst rs8", {7'b0, rs8_o}, 8'd0);
        check("rst en8", {7'b0, en8}, 8'd0);
        check("rst data8", data8, 8'h00);
        check("rst ready4", {7'b0, ready4}, 8'd1);
        check("rst en4", {7'b0, en4}, 8'd0);
        check("rst data4", {4'b0, data4}, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Normal data byte, long commands and their near neighbours.
        run8("w41", 8'h41, 1'b1, 10, 1'b0);
        run8("clr", 8'h01, 1'b0, 25, 1'b0);
        run8("clr_rs1", 8'h01, 1'b1, 10, 1'b0);
        run8("home", 8'h02, 1'b0, 25, 1'b0);
        run8("h04", 8'h04, 1'b0, 10, 1'b0);

        // Nibble mode: 0xA5 as instruction.
        check("n4 ready_pre", {7'b0, ready4}, 8'd1);
        d4 = 8'hA5;
        rs4 = 1'b0;
        v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        check("n4 ready_e0", {7'b0, ready4}, 8'd0);
        for (int e = 1; e <= 15; e++) begin
            @(posedge clk); #1;
            check($sformatf("n4 en_e%0d", e), {7'b0, en4},
                  {7'b0, ((e >= 1 && e <= 3) || (e >= 6 && e <= 8))});
            check($sformatf("n4 ready_e%0d", e), {7'b0, ready4}, {7'b0, (e == 15)});
            check($sformatf("n4 data_e%0d", e), {4'b0, data4}, (e < 5) ? 8'h0A : 8'h05);
            check($sformatf("n4 rs_e%0d", e), {7'b0, rs4_o}, 8'd0);
        end

        // Valid held high across three bytes: accepts at edges 0, 11, 22.
        d8 = 8'h30;
        rs8 = 1'b1;
        v8 = 1'b1;
        @(posedge clk); #1;
        d8 = 8'h31;
        check("b2b ready_e0", {7'b0, ready8}, 8'd0);
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk); #1;
            check($sformatf("b2b en_e%0d", e), {7'b0, en8},
                  {7'b0, ((e % 11) >= 1 && (e % 11) <= 3)});
            check($sformatf("b2b ready_e%0d", e), {7'b0, ready8},
                  {7'b0, ((e % 11) == 10)});
            if (en8 === 1'b1)
                check($sformatf("b2b data_e%0d", e), data8, 8'h30 + 8'(e / 11));
            if (e == 11) d8 = 8'h32;
            if (e == 22) v8 = 1'b0;
        end

        // Valid pulsed while busy is ignored; data_i churn does not leak out.
        run8("busy", 8'h12, 1'b0, 10, 1'b1);
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            check($sformatf("busy idle en_e%0d", e), {7'b0, en8}, 8'd0);
            check($sformatf("busy idle ready_e%0d", e), {7'b0, ready8}, 8'd1);
        end
        check("busy idle data", data8, 8'h12);

        // Reset asserted while E is high, between clock edges.
        d8 = 8'h77;
        rs8 = 1'b1;
        v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst en", {7'b0, en8}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async en", {7'b0, en8}, 8'd0);
        check("async rs", {7'b0, rs8_o}, 8'd0);
        check("async data", data8, 8'h00);
        check("async ready", {7'b0, ready8}, 8'd1);
        #2 rst_n = 1'b1;
        run8("post_rst", 8'h55, 1'b1, 10, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
